// File: rtl/multiply_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package multiply_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiply.sv
// Sequential unsigned multiplier: one multiplier bit per clock, start/done handshake.
// The accumulator upper half and the multiplier share one shift register.
module multiply
  import multiply_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [WIDTH-1:0]  acc_q;
  logic              busy_q;
  logic              done_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]  addend_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  mplier_d;

  // One iteration: conditional add into the upper half, then shift {carry, acc, mplier} right.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (mplier_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s    = {1'b0, acc_q} + {1'b0, addend_s};
    acc_d    = sum_s[WIDTH:1];
    mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= {WIDTH{1'b0}};
            count_q  <= {CW{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          count_q  <= count_q + CW'(1);
          // Last multiplier bit: publish the full product straight from the shifter.
          if (count_q == CW'(WIDTH - 1)) begin
            p_q     <= {acc_d, mplier_d};
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_multiply.sv
// Directed-vector bench for the shift-and-add multiplier (WIDTH=4).
module tb_multiply;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int total;
  int bad;

  multiply #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset_init();
    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (p !== 8'h00)  begin bad++; $display("FAIL reset_p: got %h want 00", p); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_products();
    logic [3:0] va [0:4];
    logic [3:0] vb [0:4];
    logic [7:0] ve [0:4];
    va = '{4'd3, 4'd15, 4'd10, 4'd8, 4'd15};
    vb = '{4'd5, 4'd1, 4'd3, 4'd8, 4'd15};
    ve = '{8'h0F, 8'h0F, 8'h1E, 8'h40, 8'hE1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a = va[i]; b = vb[i]; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL prod_busy_%0d: got %b want 1", i, busy); end
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        total++;
        if (done !== (c == 4)) begin
          bad++; $display("FAIL prod_done_%0d cyc%0d: got %b want %b", i, c, done, (c == 4));
        end
      end
      total++; if (p !== ve[i]) begin bad++; $display("FAIL prod_p_%0d: got %h want %h", i, p, ve[i]); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL prod_done_low_%0d: got %b want 0", i, done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL prod_busy_low_%0d: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk); a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    total++; if (p !== 8'h00)  begin bad++; $display("FAIL midrst_p: got %h want 00", p); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_nodone: got %0d want 0", pulses); end
    @(negedge clk); a = 4'd6; b = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL postrst_done: got %b want 1", done); end
    total++; if (p !== 8'h2A)  begin bad++; $display("FAIL postrst_p: got %h want 2a", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int pulses;
    @(negedge clk); a = 4'd0; b = 4'd15; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        total++; if (c !== 4) begin bad++; $display("FAIL zero_when: got cyc%0d want cyc4", c); end
        total++; if (p !== 8'h00) begin bad++; $display("FAIL zero_p: got %h want 00", p); end
      end
      if (c == 3) begin
        total++; if (p !== 8'h2A) begin bad++; $display("FAIL zero_hold: got %h want 2a", p); end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 4'd15; b = 4'd15;
    repeat (4) @(posedge clk);
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1: got %b want 1", done); end
    total++; if (p !== 8'h0F)  begin bad++; $display("FAIL b2b_p1: got %h want 0f", p); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
    @(posedge clk); #1; start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (p !== 8'h0F)  begin bad++; $display("FAIL b2b_hold: got %h want 0f", p); end
    @(posedge clk); #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2: got %b want 1", done); end
    total++; if (p !== 8'hE1)  begin bad++; $display("FAIL b2b_p2: got %h want e1", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    @(negedge clk); a = 4'd10; b = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    a = 4'd7; b = 4'd9;
    @(posedge clk); #1;
    a = 4'd12; b = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (p !== 8'h1E) begin bad++; $display("FAIL cap_p: got %h want 1e", p); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (p !== 8'h1E) begin bad++; $display("FAIL cap_hold: got %h want 1e", p); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cap_done_idle: got %b want 0", done); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset_init();
    test_products();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    test_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
